// File: rtl/dcpu_pkg.sv
// Shared definitions for the CPU data-bus controller: IO register map,
// status register layout and bus FSM encoding.
package dcpu_pkg;

    localparam logic [15:0] IO_OFS_TX     = 16'd0;
    localparam logic [15:0] IO_OFS_STATUS = 16'd1;
    localparam logic [15:0] IO_OFS_CYCLE  = 16'd2;

    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_CNT_LSB = 2;
    localparam int ST_CNT_W   = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } bus_state_e;

endpackage

// File: rtl/dbus_fifo.sv
// Small synchronous FIFO; pushes when full and pops when empty are dropped.
module dbus_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [W-1:0]             din_i,
    input  logic                     pop_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rptr_q];
    assign count_o = cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wptr_d  = wptr_q + AW'(do_push);
        rptr_d  = rptr_q + AW'(do_pop);
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/dbus_ctrl.sv
// CPU data-bus controller: routes cycles to RAM (with optional wait states)
// or to a tiny IO block holding a TX FIFO, a status word and a cycle counter.
module dbus_ctrl
    import dcpu_pkg::*;
#(
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] IO_BASE     = 16'hFF00,
    parameter int          TX_DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cs,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_dat,
    output logic [15:0] o_dat,
    output logic        o_ack,
    output logic        o_mem_cs,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_dat,
    input  logic [15:0] i_mem_dat,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready
);
    localparam int CW = $clog2(TX_DEPTH) + 1;

    bus_state_e    state_q, state_d;
    logic [2:0]    wcnt_q, wcnt_d;
    logic          we_q, we_d, io_q, io_d;
    logic          mem_vld_q;
    logic [15:0]   rdat_q, cyc_q;

    logic          is_io, tx_sel, req, ack, push, pop;
    logic [15:0]   io_ofs, io_rdata;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_cnt;

    assign io_ofs     = i_addr - IO_BASE;
    assign is_io      = (i_addr >= IO_BASE);
    assign tx_sel     = (io_ofs == IO_OFS_TX);
    assign req        = (state_q == S_IDLE) && i_cs;
    assign o_tx_valid = !i_reset && !fifo_empty;
    assign pop        = o_tx_valid && i_tx_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            we_q    <= we_d;
            io_q    <= io_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        we_d    = we_q;
        io_d    = io_q;
        case (state_q)
            S_IDLE: if (i_cs) begin
                we_d = i_we;
                io_d = is_io;
                if (!is_io) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = S_WAIT;
                        wcnt_d  = 3'(WAIT_STATES - 1);
                    end
                // A pop this same cycle frees a slot in time for the ACK-cycle push.
                end else if (i_we && tx_sel && fifo_full && !pop) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_WAIT: begin
                if (io_q) begin
                    if (!fifo_full || pop) state_d = S_ACK;
                end else if (wcnt_q == 3'd0) begin
                    state_d = S_ACK;
                end else begin
                    wcnt_d = wcnt_q - 3'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_mem_cs   = !i_reset && req && !is_io;
        o_mem_we   = o_mem_cs && i_we;
        o_mem_addr = i_addr;
        o_mem_dat  = i_dat;
        ack        = !i_reset && (state_q == S_ACK);
        o_ack      = ack;
        push       = ack && io_q && we_q && tx_sel;
        io_rdata   = '0;
        case (io_ofs)
            IO_OFS_STATUS: begin
                io_rdata[ST_FULL]                  = fifo_full;
                io_rdata[ST_EMPTY]                 = fifo_empty;
                io_rdata[ST_CNT_LSB +: ST_CNT_W]   = ST_CNT_W'(fifo_cnt);
            end
            IO_OFS_CYCLE: io_rdata = cyc_q;
            default:      io_rdata = '0;
        endcase
        // With no wait states the RAM word is still on i_mem_dat in the ack cycle.
        o_dat = '0;
        if (ack && !we_q) o_dat = io_q ? io_rdata : (mem_vld_q ? i_mem_dat : rdat_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            mem_vld_q <= 1'b0;
            rdat_q    <= '0;
            cyc_q     <= '0;
        end else begin
            mem_vld_q <= o_mem_cs;
            if (mem_vld_q) rdat_q <= i_mem_dat;
            cyc_q     <= cyc_q + 16'd1;
        end
    end

    dbus_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .push_i  (push),
        .din_i   (i_dat[7:0]),
        .pop_i   (pop),
        .dout_o  (o_tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

endmodule

// File: tb/tb_dbus_ctrl.sv
// Bench for dbus_ctrl: two instances (0 and 3 wait states) checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_dbus_ctrl;
    localparam logic [15:0] IOB = 16'hFF00;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cs[2], we[2], ack[2], mcs[2], mwe[2], txv[2], txr[2];
    logic [15:0] addr[2], wdat[2], odat[2], maddr[2], mwdat[2], mrd[2];
    logic [7:0]  txd[2];

    dbus_ctrl #(.WAIT_STATES(0), .IO_BASE(IOB), .TX_DEPTH(DEPTH)) u0 (
        .i_clk(clk), .i_reset(rst), .i_cs(cs[0]), .i_we(we[0]), .i_addr(addr[0]),
        .i_dat(wdat[0]), .o_dat(odat[0]), .o_ack(ack[0]), .o_mem_cs(mcs[0]),
        .o_mem_we(mwe[0]), .o_mem_addr(maddr[0]), .o_mem_dat(mwdat[0]),
        .i_mem_dat(mrd[0]), .o_tx_valid(txv[0]), .o_tx_data(txd[0]), .i_tx_ready(txr[0]));

    dbus_ctrl #(.WAIT_STATES(3), .IO_BASE(IOB), .TX_DEPTH(DEPTH)) u3 (
        .i_clk(clk), .i_reset(rst), .i_cs(cs[1]), .i_we(we[1]), .i_addr(addr[1]),
        .i_dat(wdat[1]), .o_dat(odat[1]), .o_ack(ack[1]), .o_mem_cs(mcs[1]),
        .o_mem_we(mwe[1]), .o_mem_addr(maddr[1]), .o_mem_dat(mwdat[1]),
        .i_mem_dat(mrd[1]), .o_tx_valid(txv[1]), .o_tx_data(txd[1]), .i_tx_ready(txr[1]));

    int n_chk = 0;
    int n_fail = 0;
    int tcyc = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, tcyc);
        end
    endtask

    // RAM behind each instance: read data one cycle after the select.
    logic [15:0] ram[2][256];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) ram[k][16] <= 16'h1234;
            else if (mcs[k]) begin
                if (mwe[k]) ram[k][maddr[k][7:0]] <= mwdat[k];
                mrd[k] <= ram[k][maddr[k][7:0]];
            end
        end
    end

    // Transaction-level model
    bit          m_busy[2], m_we[2], m_io[2];
    logic [15:0] m_addr[2], m_dat[2];
    int          m_ackc[2], m_cyc[2], mh[2], mn[2];
    logic [15:0] mref[2][256];
    logic [7:0]  mq[2][16];
    int          n = 0;

    function automatic int ws(int k);
        return (k == 0) ? 0 : 3;
    endfunction

    always @(negedge clk) begin
        bit pop, eack, emcs;
        logic [15:0] edat;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                chk("rst_ack", 32'(ack[k]), 0);
                chk("rst_mem_cs", 32'(mcs[k]), 0);
                chk("rst_tx_valid", 32'(txv[k]), 0);
                chk("rst_dat", 32'(odat[k]), 0);
                m_busy[k] = 0; mh[k] = 0; mn[k] = 0; m_cyc[k] = 0;
                mref[k][16] = 16'h1234;
            end else begin
                pop  = (mn[k] > 0) && txr[k];
                emcs = 0;
                if (!m_busy[k] && cs[k]) begin
                    m_busy[k] = 1; m_we[k] = we[k]; m_addr[k] = addr[k];
                    m_dat[k] = wdat[k]; m_io[k] = (addr[k] >= IOB);
                    if (!m_io[k]) begin
                        emcs = 1;
                        m_ackc[k] = n + 1 + ws(k);
                        if (we[k]) mref[k][addr[k][7:0]] = wdat[k];
                    end else if (we[k] && addr[k] == IOB && mn[k] == DEPTH && !pop)
                        m_ackc[k] = -1;
                    else
                        m_ackc[k] = n + 1;
                end else if (m_busy[k] && m_ackc[k] < 0 && pop) begin
                    m_ackc[k] = n + 1;
                end
                eack = m_busy[k] && (m_ackc[k] == n);
                edat = 16'h0;
                if (eack && !m_we[k]) begin
                    if (!m_io[k]) edat = mref[k][m_addr[k][7:0]];
                    else if (m_addr[k] == IOB + 16'd1)
                        edat = 16'(mn[k] * 4 + (mn[k] == 0 ? 2 : 0) + (mn[k] == DEPTH ? 1 : 0));
                    else if (m_addr[k] == IOB + 16'd2)
                        edat = 16'(m_cyc[k]);
                end
                chk("ack", 32'(ack[k]), 32'(eack));
                chk("rdata", 32'(odat[k]), 32'(edat));
                chk("mem_cs", 32'(mcs[k]), 32'(emcs));
                if (emcs) begin
                    chk("mem_we", 32'(mwe[k]), 32'(we[k]));
                    chk("mem_addr", 32'(maddr[k]), 32'(addr[k]));
                    chk("mem_wdat", 32'(mwdat[k]), 32'(wdat[k]));
                end
                chk("tx_valid", 32'(txv[k]), 32'(mn[k] > 0));
                if (mn[k] > 0) chk("tx_data", 32'(txd[k]), 32'(mq[k][mh[k]]));
                if (pop) begin mh[k] = (mh[k] + 1) % 16; mn[k]--; end
                if (eack && m_we[k] && m_io[k] && m_addr[k] == IOB) begin
                    mq[k][(mh[k] + mn[k]) % 16] = m_dat[k][7:0];
                    mn[k]++;
                end
                if (eack) m_busy[k] = 0;
                m_cyc[k] = (m_cyc[k] + 1) % 65536;
            end
        end
        n++;
    end

    task automatic xfer(input int k, input bit w, input logic [15:0] a, input logic [15:0] d,
                        input bit hold, output logic [15:0] rd, output int lat, output int acyc);
        @(posedge clk); #1;
        cs[k] = 1'b1; we[k] = w; addr[k] = a; wdat[k] = d;
        @(negedge clk);
        lat = 0;
        while (!ack[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("ack_seen", 32'(ack[k]), 1);
        rd = odat[k];
        acyc = tcyc;
        if (!hold) begin
            @(posedge clk); #1;
            cs[k] = 1'b0;
        end
    endtask

    initial begin
        logic [15:0] rd, rd5, c1, c2;
        int lat, lat5, ac, ac5, popc;
        logic [7:0] popd;
        popc = 0; popd = 8'h0;
        for (int k = 0; k < 2; k++) begin
            cs[k] = 0; we[k] = 0; addr[k] = 0; wdat[k] = 0; txr[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        xfer(0, 0, IOB + 16'd1, 0, 0, rd, lat, ac);
        chk("reset_status", 32'(rd), 32'h0002);
        chk("io_lat", 32'(lat), 1);

        xfer(0, 0, 16'h0010, 0, 0, rd, lat, ac);
        chk("rd_ws0_data", 32'(rd), 32'h1234);
        chk("rd_ws0_lat", 32'(lat), 1);

        xfer(1, 1, 16'h0020, 16'hBEEF, 0, rd, lat, ac);
        chk("wr_ws3_lat", 32'(lat), 4);
        xfer(1, 0, 16'h0020, 0, 0, rd, lat, ac);
        chk("rd_ws3_data", 32'(rd), 32'hBEEF);
        chk("rd_ws3_lat", 32'(lat), 4);

        // Fetch then held-cs reads of the cycle counter
        xfer(0, 0, 16'h0010, 0, 1, rd, lat, ac);
        xfer(0, 0, IOB + 16'd2, 0, 1, c1, lat, ac);
        chk("b2b_lat1", 32'(lat), 1);
        xfer(0, 0, IOB + 16'd2, 0, 0, c2, lat, ac);
        chk("b2b_lat2", 32'(lat), 1);
        chk("cyc_delta", 32'(16'(c2 - c1)), 2);

        xfer(0, 1, IOB + 16'd2, 16'h5555, 0, rd, lat, ac);
        chk("cyc_wr_lat", 32'(lat), 1);
        xfer(0, 0, IOB + 16'd7, 0, 0, rd, lat, ac);
        chk("unmapped_rd", 32'(rd), 0);

        for (int i = 1; i <= 4; i++) begin
            xfer(0, 1, IOB, 16'(i), 0, rd, lat, ac);
            chk("tx_wr_lat", 32'(lat), 1);
        end
        xfer(0, 0, IOB + 16'd1, 0, 0, rd, lat, ac);
        chk("full_status", 32'(rd), 32'h0011);

        fork
            xfer(0, 1, IOB, 16'h0005, 0, rd5, lat5, ac5);
            begin
                repeat (6) @(posedge clk);
                #1 txr[0] = 1'b1;
                @(negedge clk);
                popc = tcyc;
                popd = txd[0];
            end
        join
        chk("first_pop_data", 32'(popd), 32'h01);
        chk("stall_release", 32'(ac5), 32'(popc + 1));
        chk("stall_lat", 32'(lat5), 6);

        repeat (8) @(posedge clk);
        xfer(0, 0, IOB + 16'd1, 0, 0, rd, lat, ac);
        chk("drained_status", 32'(rd), 32'h0002);

        // Reset during the wait states of a 3-wait read
        @(posedge clk); #1;
        cs[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0010;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; cs[1] = 1'b0;
        repeat (6) @(posedge clk);
        xfer(1, 0, IOB + 16'd1, 0, 0, rd, lat, ac);
        chk("post_abort_status", 32'(rd), 32'h0002);
        chk("post_abort_lat", 32'(lat), 1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
